// File: rtl/r4_div_pkg.sv
// Definitions shared by the radix-4 divider blocks: the one-hot quotient digit
// encoding (also used by the quotient-digit selector) and the OTFC control states.
package r4_div_pkg;

  localparam logic [4:0] QUO_NEG_2 = 5'b10000;
  localparam logic [4:0] QUO_NEG_1 = 5'b01000;
  localparam logic [4:0] QUO_ZERO  = 5'b00100;
  localparam logic [4:0] QUO_POS_1 = 5'b00010;
  localparam logic [4:0] QUO_POS_2 = 5'b00001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_DONE
  } otfc_state_e;

endpackage

// File: rtl/r4_otfc_step.sv
// Single-digit on-the-fly conversion step: appends one radix-4 digit to Q and
// QM = Q - 1 by selecting between the two registers, so no carry chain is needed.
module r4_otfc_step
  import r4_div_pkg::*;
#(
  parameter int QUO_W = 54
) (
  input  logic [4:0]       dig_i,
  input  logic [QUO_W-1:0] quo_i,
  input  logic [QUO_W-1:0] quo_m1_i,
  output logic [QUO_W-1:0] quo_o,
  output logic [QUO_W-1:0] quo_m1_o,
  output logic             err_o
);

  // NOTE: every output gets a default before the case so no latch can be inferred
  // for a digit value the case does not list.
  always_comb begin
    quo_o    = {quo_i[QUO_W-3:0], 2'b00};
    quo_m1_o = {quo_m1_i[QUO_W-3:0], 2'b11};
    err_o    = 1'b0;
    case (dig_i)
      QUO_POS_2: begin
        quo_o    = {quo_i[QUO_W-3:0], 2'b10};
        quo_m1_o = {quo_i[QUO_W-3:0], 2'b01};
      end
      QUO_POS_1: begin
        quo_o    = {quo_i[QUO_W-3:0], 2'b01};
        quo_m1_o = {quo_i[QUO_W-3:0], 2'b00};
      end
      QUO_ZERO: ;
      QUO_NEG_1: begin
        quo_o    = {quo_m1_i[QUO_W-3:0], 2'b11};
        quo_m1_o = {quo_m1_i[QUO_W-3:0], 2'b10};
      end
      QUO_NEG_2: begin
        quo_o    = {quo_m1_i[QUO_W-3:0], 2'b10};
        quo_m1_o = {quo_m1_i[QUO_W-3:0], 2'b01};
      end
      // Zero or multi-hot digits keep the 0-digit update and raise the error flag.
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/r4_otfc_acc.sv
// Radix-4 OTFC accumulator: collects a programmed number of quotient digits and
// hands Q and QM = Q - 1 to the rounding stage through a valid/ready handshake.
module r4_otfc_acc
  import r4_div_pkg::*;
#(
  parameter int QUO_W  = 54,
  parameter int ITER_W = $clog2(QUO_W/2+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              start_valid_i,
  output logic              start_ready_o,
  input  logic [ITER_W-1:0] iter_num_i,
  input  logic              quo_dig_valid_i,
  output logic              quo_dig_ready_o,
  input  logic [4:0]        quo_dig_i,
  output logic              done_valid_o,
  input  logic              done_ready_i,
  output logic [QUO_W-1:0]  quo_o,
  output logic [QUO_W-1:0]  quo_m1_o,
  output logic              err_o
);

  otfc_state_e       state_q;
  logic [ITER_W-1:0] count_q;
  logic [QUO_W-1:0]  quo_q;
  logic [QUO_W-1:0]  quo_m1_q;
  logic              err_q;

  logic [QUO_W-1:0]  quo_d;
  logic [QUO_W-1:0]  quo_m1_d;
  logic              step_err;

  r4_otfc_step #(
    .QUO_W (QUO_W)
  ) u_step (
    .dig_i    (quo_dig_i),
    .quo_i    (quo_q),
    .quo_m1_i (quo_m1_q),
    .quo_o    (quo_d),
    .quo_m1_o (quo_m1_d),
    .err_o    (step_err)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      quo_q    <= '0;
      quo_m1_q <= '1;
      err_q    <= 1'b0;
    end else if (flush_i) begin
      // Abort keeps Q/QM as they are; only control state and the sticky error clear.
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_valid_i) begin
            quo_q    <= '0;
            quo_m1_q <= '1;
            count_q  <= iter_num_i;
            err_q    <= 1'b0;
            state_q  <= (iter_num_i == '0) ? ST_DONE : ST_ACC;
          end
        end
        ST_ACC: begin
          if (quo_dig_valid_i) begin
            quo_q    <= quo_d;
            quo_m1_q <= quo_m1_d;
            count_q  <= count_q - ITER_W'(1);
            err_q    <= err_q | step_err;
            if (count_q == ITER_W'(1)) state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (done_ready_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign start_ready_o   = (state_q == ST_IDLE);
  assign quo_dig_ready_o = (state_q == ST_ACC);
  assign done_valid_o    = (state_q == ST_DONE);
  assign quo_o           = quo_q;
  assign quo_m1_o        = quo_m1_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_r4_otfc_acc.sv
// Bench for r4_otfc_acc: directed runs on 8- and 54-bit instances sharing one
// stimulus, then random digit streams on the 54-bit instance, with a result scoreboard.
module tb_r4_otfc_acc;

  localparam int W   = 54;
  localparam int W8  = 8;
  localparam int IW  = $clog2(W/2+1);
  localparam int IW8 = $clog2(W8/2+1);

  localparam logic [4:0] D_N2 = 5'b10000;
  localparam logic [4:0] D_N1 = 5'b01000;
  localparam logic [4:0] D_Z  = 5'b00100;
  localparam logic [4:0] D_P1 = 5'b00010;
  localparam logic [4:0] D_P2 = 5'b00001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          start_valid = 1'b0;
  logic [IW-1:0] iter = '0;
  logic          dig_valid = 1'b0;
  logic [4:0]    dig = '0;
  logic          done_ready = 1'b0;

  logic          start_ready, dig_ready, done_valid, err;
  logic [W-1:0]  quo, quo_m1;
  logic          start_ready8, dig_ready8, done_valid8, err8;
  logic [W8-1:0] quo8, quo_m18;

  r4_otfc_acc #(.QUO_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .start_valid_i(start_valid), .start_ready_o(start_ready), .iter_num_i(iter),
    .quo_dig_valid_i(dig_valid), .quo_dig_ready_o(dig_ready), .quo_dig_i(dig),
    .done_valid_o(done_valid), .done_ready_i(done_ready),
    .quo_o(quo), .quo_m1_o(quo_m1), .err_o(err)
  );

  r4_otfc_acc #(.QUO_W(W8)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .start_valid_i(start_valid), .start_ready_o(start_ready8), .iter_num_i(iter[IW8-1:0]),
    .quo_dig_valid_i(dig_valid), .quo_dig_ready_o(dig_ready8), .quo_dig_i(dig),
    .done_valid_o(done_valid8), .done_ready_i(done_ready),
    .quo_o(quo8), .quo_m1_o(quo_m18), .err_o(err8)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk8  = 1'b1;

  typedef struct packed {
    logic [W-1:0] q;
    logic         err;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] ref_q;
  logic         ref_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: Q = 4*Q + digit, modulo 2^W; malformed digits count as 0.
  task automatic ref_apply(input logic [4:0] d);
    case (d)
      D_P2:    ref_q = (ref_q << 2) + W'(2);
      D_P1:    ref_q = (ref_q << 2) + W'(1);
      D_Z:     ref_q = ref_q << 2;
      D_N1:    ref_q = (ref_q << 2) - W'(1);
      D_N2:    ref_q = (ref_q << 2) - W'(2);
      default: begin
        ref_q   = ref_q << 2;
        ref_err = 1'b1;
      end
    endcase
  endtask

  task automatic do_start(input int n);
    bit ok;
    ok = 1'b0;
    start_valid = 1'b1;
    iter = IW'(n);
    for (int i = 0; i < 100 && !ok; i++) begin
      ok = start_ready;
      tick();
    end
    chk("start_accepted", ok, 1);
    start_valid = 1'b0;
    ref_q = '0;
    ref_err = 1'b0;
  endtask

  task automatic do_digit(input logic [4:0] d, input int gap);
    bit ok;
    ok = 1'b0;
    dig_valid = 1'b0;
    repeat (gap) tick();
    dig_valid = 1'b1;
    dig = d;
    for (int i = 0; i < 100 && !ok; i++) begin
      ok = dig_ready;
      tick();
    end
    chk("digit_accepted", ok, 1);
    dig_valid = 1'b0;
    ref_apply(d);
  endtask

  task automatic push_exp();
    exp_t e;
    e.q = ref_q;
    e.err = ref_err;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && !done_valid; i++) tick();
    chk("done_seen", done_valid, 1);
  endtask

  task automatic check_result(input string tag);
    exp_t         e;
    logic [W-1:0] qm_exp;
    logic [7:0]   q8_exp, qm8_exp;
    chk("sb_nonempty", sb.size() > 0, 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    qm_exp = e.q - W'(1);
    chk({tag, "_q"}, quo, e.q);
    chk({tag, "_qm"}, quo_m1, qm_exp);
    chk({tag, "_err"}, err, e.err);
    if (chk8) begin
      q8_exp = e.q[7:0];
      qm8_exp = q8_exp - 8'd1;
      chk({tag, "_q8"}, quo8, q8_exp);
      chk({tag, "_qm8"}, quo_m18, qm8_exp);
      chk({tag, "_err8"}, err8, e.err);
    end
  endtask

  task automatic ack();
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      total += 2;
      assert (quo_m1 === quo - W'(1)) else begin
        bad++;
        $error("FAIL qm_invariant observed=0x%0h expected=0x%0h", quo_m1, quo - W'(1));
      end
      assert (quo_m18 === quo8 - 8'd1) else begin
        bad++;
        $error("FAIL qm_invariant8 observed=0x%0h expected=0x%0h", quo_m18, quo8 - 8'd1);
      end
    end
  end

  initial begin
    logic [W-1:0] all1;
    all1 = '1;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_start_ready", start_ready, 1);
    chk("rst_dig_ready", dig_ready, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_quo", quo, 0);
    chk("rst_quo_m1", quo_m1, all1);
    chk("rst_err", err, 0);
    chk("rst_quo_m1_8", quo_m18, 8'hFF);
    #9 rst_n = 1'b1;
    tick();

    // +2,+1,0,-1 back to back
    do_start(4);
    do_digit(D_P2, 0); do_digit(D_P1, 0); do_digit(D_Z, 0); do_digit(D_N1, 0);
    chk("t1_latency", done_valid, 1);
    push_exp();
    wait_done();
    check_result("t1");
    ack();

    // single -2 digit wraps below zero
    do_start(1);
    do_digit(D_N2, 0);
    chk("t2_latency", done_valid, 1);
    push_exp();
    wait_done();
    check_result("t2");
    ack();

    // multi-hot digit behaves as 0 and sets err
    do_start(2);
    do_digit(5'b00011, 0); do_digit(D_P1, 0);
    push_exp();
    wait_done();
    check_result("t3");
    ack();

    // zero digits: DONE right after start
    do_start(0);
    chk("t4_latency", done_valid, 1);
    push_exp();
    check_result("t4");
    ack();

    // flush mid-run with a digit offered in the same cycle
    do_start(4);
    do_digit(5'b00000, 0); do_digit(D_P1, 0);
    chk("t5_pre_flush_err", err, 1);
    flush = 1'b1; dig_valid = 1'b1; dig = D_P2;
    tick();
    flush = 1'b0; dig_valid = 1'b0;
    chk("t5_start_ready", start_ready, 1);
    chk("t5_dig_ready", dig_ready, 0);
    chk("t5_done_valid", done_valid, 0);
    chk("t5_err_cleared", err, 0);
    chk("t5_quo_held", quo, ref_q);
    do_start(3);
    do_digit(D_N1, 0); do_digit(D_N1, 0); do_digit(D_P2, 0);
    push_exp();
    wait_done();
    check_result("t5_after");
    ack();

    // DONE held for 3 cycles with a start request pending
    do_start(2);
    do_digit(D_P1, 1); do_digit(D_N2, 2);
    push_exp();
    wait_done();
    check_result("t6");
    start_valid = 1'b1;
    iter = IW'(1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_hold_valid", done_valid, 1);
      chk("t6_hold_start_ready", start_ready, 0);
      chk("t6_hold_quo", quo, ref_q);
    end
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk("t6_release_idle", start_ready, 1);
    chk("t6_release_valid", done_valid, 0);
    chk("t6_release_no_acc", dig_ready, 0);
    tick();
    start_valid = 1'b0;
    chk("t6_start_taken", start_ready, 0);
    chk("t6_in_acc", dig_ready, 1);
    ref_q = '0;
    ref_err = 1'b0;
    do_digit(D_P1, 0);
    push_exp();
    wait_done();
    check_result("t6_next");
    ack();

    // asynchronous reset mid-accumulation
    do_start(4);
    do_digit(D_P2, 0); do_digit(D_P1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_quo", quo, 0);
    chk("arst_quo_m1", quo_m1, all1);
    chk("arst_start_ready", start_ready, 1);
    chk("arst_dig_ready", dig_ready, 0);
    chk("arst_done_valid", done_valid, 0);
    #1 rst_n = 1'b1;
    tick();

    // random full-width streams with valid gaps and delayed acks
    chk8 = 1'b0;
    for (int r = 0; r < 30; r++) begin
      int n;
      n = $urandom_range(1, W/2);
      do_start(n);
      for (int k = 0; k < n; k++) begin
        logic [4:0] d;
        if ($urandom_range(0, 15) == 0) d = 5'($urandom);
        else d = 5'b00001 << $urandom_range(0, 4);
        do_digit(d, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end
      chk("rnd_latency", done_valid, 1);
      push_exp();
      wait_done();
      check_result("rnd");
      repeat ($urandom_range(0, 3)) tick();
      ack();
    end

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
